if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/my_pkg.sv | 11 +
 rtl/if_queue.sv | 54 +++++
 rtl/if_fetch.sv | 112 +++++++++++
 tb/tb_if_fetch.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_pkg.sv
// rtl/my_pkg.sv - shared parameters and types for the instruction fetch unit
package my_pkg;
    localparam int DATA_WIDTH = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_1000;
    localparam int IF_QUEUE_DEPTH = 2;

    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_FLUSH = 1'b1
    } fetch_state_e;
endpackage

// File: rtl/if_queue.sv
// rtl/if_queue.sv - two-entry fetch response FIFO with synchronous clear
module if_queue
    import my_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head_data
);
    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       cnt;
    logic             do_push;
    logic             do_pop;

    // a push into a full queue is only legal when the head leaves in the same cycle
    assign do_pop  = pop && (cnt != 2'd0);
    assign do_push = push && ((cnt != 2'(IF_QUEUE_DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (clear) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign empty     = (cnt == 2'd0);
    assign count     = cnt;
    assign head_data = mem[rd_ptr];
endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - credit-limited instruction fetch with redirect flush
module if_fetch #(
    parameter int DATA_WIDTH = my_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [DATA_WIDTH-1:0] req_addr,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_pc,
    output logic [DATA_WIDTH-1:0] inst_data
);
    import my_pkg::*;

    localparam logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(RESET_VECTOR);

    logic [DATA_WIDTH-1:0]   fetch_pc;
    logic [DATA_WIDTH-1:0]   resp_pc;
    logic [DATA_WIDTH-1:0]   redirect_aligned;
    logic [1:0]              outstanding;
    logic [1:0]              discard_cnt;
    logic [1:0]              discard_next;
    logic [1:0]              q_count;
    fetch_state_e            state;
    fetch_state_e            state_next;
    logic                    accept;
    logic                    rsp_ok;
    logic                    push;
    logic                    pop;
    logic                    q_empty;
    logic [2*DATA_WIDTH-1:0] q_head;
    logic                    unused_redirect_lsbs;

    assign redirect_aligned     = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // every issued request must have a guaranteed queue slot for its response
    assign req_valid = !rst && !redirect_valid
                       && (({1'b0, outstanding} + {1'b0, q_count}) < 3'(IF_QUEUE_DEPTH));
    assign req_addr  = fetch_pc;
    assign accept    = req_valid && req_ready;
    assign rsp_ok    = rsp_valid && (outstanding != 2'd0);
    assign pop       = !q_empty && inst_ready && !redirect_valid;

    always_comb begin
        discard_next = discard_cnt;
        push         = 1'b0;
        if (redirect_valid) begin
            discard_next = outstanding - {1'b0, rsp_ok};
        end else if (rsp_ok) begin
            if (state == FETCH_FLUSH) begin
                discard_next = discard_cnt - 2'd1;
            end else begin
                push = 1'b1;
            end
        end
        state_next = (discard_next == 2'd0) ? FETCH_RUN : FETCH_FLUSH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= 2'd0;
            discard_cnt <= 2'd0;
            state       <= FETCH_RUN;
        end else begin
            state       <= state_next;
            discard_cnt <= discard_next;
            outstanding <= outstanding + {1'b0, accept} - {1'b0, rsp_ok};
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
                resp_pc  <= redirect_aligned;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + DATA_WIDTH'(4);
                end
                if (push) begin
                    resp_pc <= resp_pc + DATA_WIDTH'(4);
                end
            end
        end
    end

    if_queue #(
        .WIDTH(2 * DATA_WIDTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .clear    (redirect_valid),
        .push     (push),
        .push_data({resp_pc, rsp_data}),
        .pop      (pop),
        .empty    (q_empty),
        .count    (q_count),
        .head_data(q_head)
    );

    assign inst_valid = !q_empty;
    assign inst_pc    = q_empty ? '0 : q_head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign inst_data  = q_empty ? '0 : q_head[DATA_WIDTH-1:0];

    rsp_without_request: assert property (
        @(posedge clk) disable iff (rst) !(rsp_valid && (outstanding == 2'd0))
    );
endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - randomized self-checking bench for if_fetch
module tb_if_fetch;
    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;

    if_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_pc       (inst_pc),
        .inst_data     (inst_data)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    logic [31:0] got_pc[$];
    logic [31:0] acc_addr[$];
    int          tests;
    int          fails;
    int          cyc;
    int          qcnt;
    int          dis;
    int          lat_lo;
    int          lat_hi;
    int          n_accept;
    int          n_consumed;
    int          first_iv_cyc;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        inst_ready     = 1'b0;
        mem_q.delete();
        got_pc.delete();
        acc_addr.delete();
        qcnt         = 0;
        dis          = 0;
        cyc          = 0;
        n_accept     = 0;
        n_consumed   = 0;
        first_iv_cyc = 0;
        exp_pc       = 32'h0000_1000;
        exp_req      = 32'h0000_1000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // one clock cycle: drive memory/redirect at the negedge, judge handshakes before the posedge
    task automatic cycle(input bit redir, input logic [31:0] rpc);
        int          pend0;
        bit          rsp;
        logic [31:0] raddr;
        int          lat;
        cyc++;
        pend0 = mem_q.size();
        rsp   = 1'b0;
        raddr = '0;
        if (pend0 > 0 && mem_q[0].due <= cyc) begin
            rsp   = 1'b1;
            raddr = mem_q[0].addr;
            void'(mem_q.pop_front());
        end
        rsp_valid      = rsp;
        rsp_data       = rsp ? mem_data(raddr) : 32'h0;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        tests++;
        if (req_valid !== (!redir && (pend0 + qcnt < 2))) begin
            fails++;
            $display("FAIL req_valid_credit cyc=%0d got=%0b exp=%0b", cyc, req_valid,
                     (!redir && (pend0 + qcnt < 2)));
        end
        tests++;
        if (inst_valid !== (qcnt != 0)) begin
            fails++;
            $display("FAIL inst_valid cyc=%0d got=%0b exp=%0b", cyc, inst_valid, (qcnt != 0));
        end
        if (inst_valid === 1'b1 && first_iv_cyc == 0) first_iv_cyc = cyc;
        if (inst_valid === 1'b1 && inst_ready && !redir && qcnt > 0) begin
            tests++;
            if (inst_pc !== exp_pc || inst_data !== mem_data(exp_pc)) begin
                fails++;
                $display("FAIL inst_stream cyc=%0d got pc=%h data=%h exp pc=%h data=%h",
                         cyc, inst_pc, inst_data, exp_pc, mem_data(exp_pc));
            end
            got_pc.push_back(inst_pc);
            exp_pc = exp_pc + 32'd4;
            qcnt--;
            n_consumed++;
        end
        if (req_valid === 1'b1 && req_ready) begin
            tests++;
            if (req_addr !== exp_req) begin
                fails++;
                $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, req_addr, exp_req);
            end
            lat = int'($urandom_range(lat_hi, lat_lo));
            mem_q.push_back('{req_addr, cyc + 1 + lat});
            acc_addr.push_back(req_addr);
            exp_req = exp_req + 32'd4;
            n_accept++;
        end
        if (redir) begin
            exp_pc  = {rpc[31:2], 2'b00};
            exp_req = {rpc[31:2], 2'b00};
            dis     = pend0 - (rsp ? 1 : 0);
            qcnt    = 0;
        end else if (rsp) begin
            if (dis > 0) dis--;
            else qcnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (req_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_req_valid got=%0b exp=0", req_valid);
        end
        tests++;
        if (req_addr !== 32'h0000_1000) begin
            fails++;
            $display("FAIL reset_req_addr got=%h exp=00001000", req_addr);
        end
        tests++;
        if (inst_valid !== 1'b0 || inst_pc !== 32'h0 || inst_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_inst got valid=%0b pc=%h data=%h exp 0/0/0",
                     inst_valid, inst_pc, inst_data);
        end
        do_reset();
    endtask

    task automatic test_sequential();
        do_reset();
        lat_lo = 0; lat_hi = 0;
        req_ready = 1'b1; inst_ready = 1'b1;
        repeat (12) cycle(1'b0, 32'h0);
        tests++;
        if (first_iv_cyc != 3) begin
            fails++;
            $display("FAIL first_inst_latency got=%0d exp=3", first_iv_cyc);
        end
        tests++;
        if (got_pc.size() < 3 || got_pc[0] !== 32'h1000 || got_pc[1] !== 32'h1004
            || got_pc[2] !== 32'h1008) begin
            fails++;
            $display("FAIL seq_pcs got n=%0d first=%h exp 1000,1004,1008",
                     got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hx);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        lat_lo = 0; lat_hi = 0;
        req_ready = 1'b1; inst_ready = 1'b0;
        repeat (10) cycle(1'b0, 32'h0);
        tests++;
        if (n_accept != 2 || inst_valid !== 1'b1) begin
            fails++;
            $display("FAIL backpressure got accepts=%0d valid=%0b exp 2/1", n_accept, inst_valid);
        end
        inst_ready = 1'b1;
        repeat (10) cycle(1'b0, 32'h0);
        tests++;
        if (got_pc.size() < 2 || got_pc[0] !== 32'h1000 || got_pc[1] !== 32'h1004) begin
            fails++;
            $display("FAIL backpressure_drain got n=%0d exp >=2 from 1000", got_pc.size());
        end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        lat_lo = 3; lat_hi = 3;
        req_ready = 1'b1; inst_ready = 1'b1;
        repeat (2) cycle(1'b0, 32'h0);
        tests++;
        if (mem_q.size() != 2) begin
            fails++;
            $display("FAIL flush_setup outstanding got=%0d exp=2", mem_q.size());
        end
        lat_lo = 0; lat_hi = 0;
        got_pc.delete();
        cycle(1'b1, 32'h0000_2002);
        repeat (15) cycle(1'b0, 32'h0);
        tests++;
        if (got_pc.size() < 1 || got_pc[0] !== 32'h2000) begin
            fails++;
            $display("FAIL flush_first_pc got n=%0d pc=%h exp 00002000", got_pc.size(),
                     (got_pc.size() > 0) ? got_pc[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_same_rsp();
        do_reset();
        lat_lo = 0; lat_hi = 0;
        req_ready = 1'b1; inst_ready = 1'b1;
        cycle(1'b0, 32'h0);
        req_ready = 1'b0;
        cycle(1'b1, 32'h0000_3000);
        req_ready = 1'b1;
        got_pc.delete();
        repeat (6) cycle(1'b0, 32'h0);
        tests++;
        if (first_iv_cyc != 5 || got_pc.size() < 1 || got_pc[0] !== 32'h3000) begin
            fails++;
            $display("FAIL redirect_same_rsp got first_cyc=%0d n=%0d exp cyc 5 pc 00003000",
                     first_iv_cyc, got_pc.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        lat_lo = 0; lat_hi = 0;
        req_ready = 1'b1; inst_ready = 1'b1;
        cycle(1'b1, 32'hFFFF_FFFC);
        repeat (8) cycle(1'b0, 32'h0);
        tests++;
        if (acc_addr.size() < 2 || acc_addr[0] !== 32'hFFFF_FFFC || acc_addr[1] !== 32'h0) begin
            fails++;
            $display("FAIL wrap_req_addr got n=%0d first=%h exp fffffffc,00000000",
                     acc_addr.size(), (acc_addr.size() > 0) ? acc_addr[0] : 32'hx);
        end
        tests++;
        if (got_pc.size() < 2 || got_pc[0] !== 32'hFFFF_FFFC || got_pc[1] !== 32'h0) begin
            fails++;
            $display("FAIL wrap_inst_pc got n=%0d exp fffffffc,00000000", got_pc.size());
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        lat_lo = 0; lat_hi = 0;
        req_ready = 1'b1; inst_ready = 1'b0;
        repeat (6) cycle(1'b0, 32'h0);
        tests++;
        if (mem_q.size() != 0 || inst_valid !== 1'b1) begin
            fails++;
            $display("FAIL midflight_setup got outstanding=%0d valid=%0b exp 0/1",
                     mem_q.size(), inst_valid);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (inst_valid !== 1'b0 || req_addr !== 32'h0000_1000 || req_valid !== 1'b0) begin
            fails++;
            $display("FAIL async_reset got valid=%0b addr=%h req=%0b exp 0/00001000/0",
                     inst_valid, req_addr, req_valid);
        end
        do_reset();
        req_ready = 1'b1; inst_ready = 1'b1;
        repeat (8) cycle(1'b0, 32'h0);
        tests++;
        if (got_pc.size() < 1 || got_pc[0] !== 32'h1000) begin
            fails++;
            $display("FAIL post_reset_pc got n=%0d exp first 00001000", got_pc.size());
        end
    endtask

    task automatic test_random();
        bit          redir;
        logic [31:0] rpc;
        do_reset();
        lat_lo = 0; lat_hi = 3;
        for (int i = 0; i < 800; i++) begin
            req_ready  = ($urandom_range(3, 0) != 0);
            inst_ready = ($urandom_range(2, 0) != 0);
            redir      = ($urandom_range(19, 0) == 0);
            rpc        = $urandom;
            cycle(redir, rpc);
        end
        tests++;
        if (n_consumed < 50) begin
            fails++;
            $display("FAIL random_progress got=%0d exp>=50", n_consumed);
        end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        inst_ready     = 1'b0;
        lat_lo         = 0;
        lat_hi         = 0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_flush();
        test_redirect_same_rsp();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
